// File: rtl/vga_dac_palette.sv
// 256 x 18-bit VGA colour palette: 1-cycle pixel lookup port plus the
// classic CPU DAC register model (read/write index, R-G-B data sequencing, state).
module vga_dac_palette #(
  parameter int NUM_ENTRIES = 256,
  parameter int COMP_WIDTH  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_access,
  input  logic                      bus_wr_en,
  input  logic [1:0]                bus_reg,
  input  logic [7:0]                bus_wdata,
  output logic [7:0]                bus_rdata,
  output logic                      bus_ack,
  input  logic [7:0]                vga_dac_idx,
  output logic [3*COMP_WIDTH-1:0]   vga_dac_rd
);

  localparam int  WORD_W     = 3 * COMP_WIDTH;
  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  logic [WORD_W-1:0]     mem [NUM_ENTRIES];

  logic                  bus_ack_q, bus_ack_d;
  logic [7:0]            bus_rdata_q, bus_rdata_d;
  logic [WORD_W-1:0]     vga_dac_rd_q;
  logic [7:0]            wr_idx_q, wr_idx_d;
  logic [7:0]            rd_idx_q, rd_idx_d;
  logic [1:0]            comp_cnt_q, comp_cnt_d;
  logic                  mode_q, mode_d;
  logic [COMP_WIDTH-1:0] r_hold_q, r_hold_d;
  logic [COMP_WIDTH-1:0] g_hold_q, g_hold_d;

  logic                  accept_s;
  logic                  ram_we_s;
  logic [WORD_W-1:0]     ram_wdata_s;
  logic [WORD_W-1:0]     ram_rword_s;
  logic [COMP_WIDTH-1:0] rd_comp_s;
  logic [7:0]            state_byte_s;

  assign accept_s     = bus_access && !bus_ack_q;
  assign ram_rword_s  = mem[rd_idx_q];
  assign ram_wdata_s  = {r_hold_q, g_hold_q, bus_wdata[COMP_WIDTH-1:0]};
  assign ram_we_s     = accept_s && bus_wr_en && (bus_reg == 2'd2) &&
                        (comp_cnt_q == 2'd2) && !reset;
  assign state_byte_s = (mode_q == MODE_READ) ? 8'h03 : 8'h00;

  // Select the component of the CPU-side read word addressed by comp_cnt.
  always_comb begin
    rd_comp_s = '0;
    case (comp_cnt_q)
      2'd0:    rd_comp_s = ram_rword_s[3*COMP_WIDTH-1:2*COMP_WIDTH];
      2'd1:    rd_comp_s = ram_rword_s[2*COMP_WIDTH-1:COMP_WIDTH];
      2'd2:    rd_comp_s = ram_rword_s[COMP_WIDTH-1:0];
      default: rd_comp_s = '0;
    endcase
  end

  // Register-model next state for an accepted bus transaction.
  always_comb begin
    bus_ack_d   = accept_s;
    bus_rdata_d = bus_rdata_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    comp_cnt_d  = comp_cnt_q;
    mode_d      = mode_q;
    r_hold_d    = r_hold_q;
    g_hold_d    = g_hold_q;
    if (accept_s) begin
      if (bus_wr_en) begin
        case (bus_reg)
          2'd0: begin
            rd_idx_d   = bus_wdata;
            mode_d     = MODE_READ;
            comp_cnt_d = 2'd0;
          end
          2'd1: begin
            wr_idx_d   = bus_wdata;
            mode_d     = MODE_WRITE;
            comp_cnt_d = 2'd0;
            r_hold_d   = '0;
            g_hold_d   = '0;
          end
          2'd2: begin
            case (comp_cnt_q)
              2'd0:    r_hold_d = bus_wdata[COMP_WIDTH-1:0];
              2'd1:    g_hold_d = bus_wdata[COMP_WIDTH-1:0];
              default: r_hold_d = r_hold_q;
            endcase
            if (comp_cnt_q == 2'd2) begin
              wr_idx_d   = wr_idx_q + 8'd1;
              comp_cnt_d = 2'd0;
            end else begin
              comp_cnt_d = comp_cnt_q + 2'd1;
            end
          end
          default: mode_d = mode_q;
        endcase
      end else begin
        case (bus_reg)
          2'd1: bus_rdata_d = wr_idx_q;
          2'd2: begin
            bus_rdata_d = 8'(rd_comp_s);
            if (comp_cnt_q == 2'd2) begin
              rd_idx_d   = rd_idx_q + 8'd1;
              comp_cnt_d = 2'd0;
            end else begin
              comp_cnt_d = comp_cnt_q + 2'd1;
            end
          end
          default: bus_rdata_d = state_byte_s;
        endcase
      end
    end else begin
      bus_rdata_d = bus_rdata_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_ack_q   <= 1'b0;
      bus_rdata_q <= 8'h00;
      wr_idx_q    <= 8'h00;
      rd_idx_q    <= 8'h00;
      comp_cnt_q  <= 2'd0;
      mode_q      <= MODE_WRITE;
      r_hold_q    <= '0;
      g_hold_q    <= '0;
    end else begin
      bus_ack_q   <= bus_ack_d;
      bus_rdata_q <= bus_rdata_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      comp_cnt_q  <= comp_cnt_d;
      mode_q      <= mode_d;
      r_hold_q    <= r_hold_d;
      g_hold_q    <= g_hold_d;
    end
  end

  // Pixel port: registered lookup, sees the pre-commit word on a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_dac_rd_q <= '0;
    end else begin
      vga_dac_rd_q <= mem[vga_dac_idx];
    end
  end

  // Palette storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem[wr_idx_q] <= ram_wdata_s;
    end
  end

  assign bus_ack    = bus_ack_q;
  assign bus_rdata  = bus_rdata_q;
  assign vga_dac_rd = vga_dac_rd_q;

endmodule

// File: tb/tb_vga_dac_palette.sv
// Self-checking bench for vga_dac_palette: directed vector table, corner-case
// sequences and random traffic against a register-level reference model.
module tb_vga_dac_palette;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_access;
  logic        bus_wr_en;
  logic [1:0]  bus_reg;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic [7:0]  vga_dac_idx;
  logic [17:0] vga_dac_rd;

  int errors = 0;
  int checks = 0;

  vga_dac_palette #(.NUM_ENTRIES(256), .COMP_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .bus_access(bus_access), .bus_wr_en(bus_wr_en),
    .bus_reg(bus_reg), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .vga_dac_idx(vga_dac_idx), .vga_dac_rd(vga_dac_rd)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [17:0] m_mem [256];
  logic [7:0]  m_wr_idx, m_rd_idx;
  int          m_cnt;
  bit          m_read_mode;
  logic [5:0]  m_rh, m_gh;

  typedef struct {
    bit         wr;
    logic [1:0] r;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [$];

  bit          pix_en = 1'b0;
  logic [17:0] pix_exp;

  always @(posedge clk) pix_exp <= m_mem[vga_dac_idx];

  always @(negedge clk) begin
    if (pix_en) begin
      checks++;
      if (vga_dac_rd !== pix_exp) begin
        errors++;
        $display("FAIL pixel_stream idx=%02h got=%05h exp=%05h", vga_dac_idx, vga_dac_rd, pix_exp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_idx = 8'h00; m_rd_idx = 8'h00; m_cnt = 0; m_read_mode = 1'b0;
    m_rh = 6'h00; m_gh = 6'h00;
  endtask

  // Applies one transaction to the model; returns the expected read byte.
  task automatic model_xfer(input bit wr, input logic [1:0] r, input logic [7:0] d,
                            output logic [7:0] exp);
    exp = m_read_mode ? 8'h03 : 8'h00;
    if (wr) begin
      if (r == 2'd0) begin
        m_rd_idx = d; m_read_mode = 1'b1; m_cnt = 0;
      end else if (r == 2'd1) begin
        m_wr_idx = d; m_read_mode = 1'b0; m_cnt = 0; m_rh = 6'h00; m_gh = 6'h00;
      end else if (r == 2'd2) begin
        if (m_cnt == 0) m_rh = d[5:0];
        else if (m_cnt == 1) m_gh = d[5:0];
        else begin
          m_mem[m_wr_idx] = {m_rh, m_gh, d[5:0]};
          m_wr_idx = 8'((int'(m_wr_idx) + 1) % 256);
        end
        m_cnt = (m_cnt + 1) % 3;
      end
    end else begin
      if (r == 2'd1) exp = m_wr_idx;
      else if (r == 2'd2) begin
        exp = 8'((m_mem[m_rd_idx] >> (6 * (2 - m_cnt))) & 18'h3F);
        if (m_cnt == 2) m_rd_idx = 8'((int'(m_rd_idx) + 1) % 256);
        m_cnt = (m_cnt + 1) % 3;
      end
    end
  endtask

  // Drives one bus handshake; returns read data and cycles to ack.
  task automatic xfer(input bit wr, input logic [1:0] r, input logic [7:0] d,
                      output logic [7:0] q, output int lat);
    @(negedge clk);
    bus_access = 1'b1; bus_wr_en = wr; bus_reg = r; bus_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_ack && lat < 8);
    q = bus_rdata;
    bus_access = 1'b0;
  endtask

  task automatic do_op(input bit wr, input logic [1:0] r, input logic [7:0] d,
                       input bit use_texp, input logic [7:0] texp, input string name);
    logic [7:0] q, mexp;
    int lat;
    xfer(wr, r, d, q, lat);
    model_xfer(wr, r, d, mexp);
    check({name, "_ack_latency"}, 32'(lat), 32'd1);
    if (!wr) check(name, 32'(q), use_texp ? 32'(texp) : 32'(mexp));
  endtask

  task automatic add(input bit wr, input logic [1:0] r, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.wr = wr; v.r = r; v.d = d; v.exp = e;
    vecs.push_back(v);
  endtask

  logic [17:0] old_20, old_21, old_30;

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 18'h0;
    model_reset();
    reset = 1'b1; bus_access = 1'b0; bus_wr_en = 1'b0; bus_reg = 2'd0;
    bus_wdata = 8'h00; vga_dac_idx = 8'h00;

    // Directed vectors: reg 1/3 reset reads, triplet at 0x10, wrap at 0xFF, reads back.
    add(1'b0, 2'd1, 8'h00, 8'h00);
    add(1'b0, 2'd3, 8'h00, 8'h00);
    add(1'b1, 2'd1, 8'h10, 8'h00);
    add(1'b1, 2'd2, 8'h3F, 8'h00);
    add(1'b1, 2'd2, 8'h15, 8'h00);
    add(1'b1, 2'd2, 8'hEA, 8'h00);
    add(1'b0, 2'd1, 8'h00, 8'h11);
    add(1'b1, 2'd1, 8'hFF, 8'h00);
    add(1'b1, 2'd2, 8'h01, 8'h00);
    add(1'b1, 2'd2, 8'h02, 8'h00);
    add(1'b1, 2'd2, 8'h03, 8'h00);
    add(1'b1, 2'd2, 8'h04, 8'h00);
    add(1'b1, 2'd2, 8'h05, 8'h00);
    add(1'b1, 2'd2, 8'h06, 8'h00);
    add(1'b0, 2'd1, 8'h00, 8'h01);
    add(1'b0, 2'd3, 8'h00, 8'h00);
    add(1'b1, 2'd0, 8'h10, 8'h00);
    add(1'b0, 2'd2, 8'h00, 8'h3F);
    add(1'b0, 2'd2, 8'h00, 8'h15);
    add(1'b0, 2'd2, 8'h00, 8'h2A);
    add(1'b0, 2'd3, 8'h00, 8'h03);
    add(1'b0, 2'd0, 8'h00, 8'h03);
    add(1'b1, 2'd3, 8'h55, 8'h00);
    add(1'b0, 2'd1, 8'h00, 8'h01);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_bus_ack", 32'(bus_ack), 32'd0);
    check("reset_vga_dac_rd", 32'(vga_dac_rd), 32'd0);
    check("reset_bus_rdata", 32'(bus_rdata), 32'd0);

    foreach (vecs[i]) do_op(vecs[i].wr, vecs[i].r, vecs[i].d, 1'b1, vecs[i].exp,
                            $sformatf("vec%0d", i));

    // Pixel lookups of the directed entries, one cycle after presenting the index.
    @(negedge clk); vga_dac_idx = 8'h10;
    @(negedge clk); check("pix_entry_10", 32'(vga_dac_rd), 32'h3F56A);
    vga_dac_idx = 8'hFF;
    @(negedge clk); check("pix_entry_ff", 32'(vga_dac_rd), 32'h01083);
    vga_dac_idx = 8'h00;
    @(negedge clk); check("pix_entry_00", 32'(vga_dac_rd), 32'h04146);

    // Fill the whole palette with random colours so the model matches every entry.
    do_op(1'b1, 2'd1, 8'h00, 1'b0, 8'h00, "init_idx");
    for (int i = 0; i < 768; i++) do_op(1'b1, 2'd2, 8'($urandom), 1'b0, 8'h00, "init");
    do_op(1'b0, 2'd1, 8'h00, 1'b1, 8'h00, "init_wrap_idx");
    pix_en = 1'b1;

    // Partial triplet discarded by index rewrite; then commit seen by a steady pixel sweep.
    vga_dac_idx = 8'h20;
    old_20 = m_mem[8'h20];
    old_21 = m_mem[8'h21];
    do_op(1'b1, 2'd1, 8'h20, 1'b0, 8'h00, "part_idx1");
    do_op(1'b1, 2'd2, 8'h3A, 1'b0, 8'h00, "part_r");
    do_op(1'b1, 2'd2, 8'h3B, 1'b0, 8'h00, "part_g");
    do_op(1'b1, 2'd1, 8'h20, 1'b0, 8'h00, "part_idx2");
    check("part_entry_20_kept", 32'(vga_dac_rd), 32'(old_20));
    do_op(1'b1, 2'd2, 8'h01, 1'b0, 8'h00, "sweep_r");
    do_op(1'b1, 2'd2, 8'h02, 1'b0, 8'h00, "sweep_g");
    do_op(1'b1, 2'd2, 8'h03, 1'b0, 8'h00, "sweep_b");
    check("sweep_commit_cycle_old", 32'(vga_dac_rd), 32'(old_20));
    @(negedge clk);
    check("sweep_next_cycle_new", 32'(vga_dac_rd), 32'h01083);
    vga_dac_idx = 8'h21;
    repeat (2) @(negedge clk);
    check("entry_21_unchanged", 32'(vga_dac_rd), 32'(old_21));

    // Reset coincident with the committing B write: no ack, no RAM write.
    do_op(1'b1, 2'd1, 8'h30, 1'b0, 8'h00, "rst_idx");
    do_op(1'b1, 2'd2, 8'h11, 1'b0, 8'h00, "rst_r");
    do_op(1'b1, 2'd2, 8'h12, 1'b0, 8'h00, "rst_g");
    old_30 = m_mem[8'h30];
    @(negedge clk);
    pix_en = 1'b0;
    bus_access = 1'b1; bus_wr_en = 1'b1; bus_reg = 2'd2; bus_wdata = 8'h13; reset = 1'b1;
    @(negedge clk);
    check("reset_wins_no_ack", 32'(bus_ack), 32'd0);
    check("reset_wins_pix_zero", 32'(vga_dac_rd), 32'd0);
    bus_access = 1'b0; reset = 1'b0;
    model_reset();
    @(negedge clk);
    pix_en = 1'b1;
    do_op(1'b0, 2'd1, 8'h00, 1'b1, 8'h00, "post_reset_wr_idx");
    do_op(1'b0, 2'd3, 8'h00, 1'b1, 8'h00, "post_reset_state");
    vga_dac_idx = 8'h30;
    repeat (2) @(negedge clk);
    check("reset_wins_entry_30", 32'(vga_dac_rd), 32'(old_30));

    // Random mixed traffic, including mid-triplet mode mixing.
    for (int i = 0; i < 400; i++) begin
      vga_dac_idx = 8'($urandom);
      do_op(1'($urandom), 2'($urandom_range(3, 0)),
            ($urandom_range(9, 0) == 0) ? 8'($urandom) : 8'($urandom_range(2, 2) * 0 + $urandom),
            1'b0, 8'h00, $sformatf("rand%0d", i));
    end
    pix_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
